// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 port between the core A and core B L1 caches.
// Optional ARB_STARVE_GUARD_EN adds per-core starvation counters that force priority at 15.
module l2_port_arbiter #(
  parameter int unsigned n  = 32,
  parameter int unsigned AW = 15
) (
  input  logic          clock,
  input  logic          n_reset,
  input  logic          L1A_READ_REQUEST,
  input  logic          L1A_WRITE_REQUEST,
  input  logic          L1B_READ_REQUEST,
  input  logic          L1B_WRITE_REQUEST,
  input  logic [AW-1:0] L1A_word_address,
  input  logic [AW-1:0] L1B_word_address,
  input  logic [n-1:0]  L1A_write_word,
  input  logic [n-1:0]  L1B_write_word,
  input  logic          L2_busy_in,
  input  logic [n-1:0]  L2_wdata,
  output logic          L2_read_request,
  output logic          L2_write_request,
  output logic [AW-1:0] L2_word_address,
  output logic [n-1:0]  L2_rdata,
  output logic [n-1:0]  L1A_read_word,
  output logic [n-1:0]  L1B_read_word,
  output logic          done_A,
  output logic          done_B,
  output logic          L2_busy_out_A,
  output logic          L2_busy_out_B,
  output logic          others_read_requests_A,
  output logic          others_read_requests_B,
  output logic          others_write_requests_A,
  output logic          others_write_requests_B,
  output logic [AW-1:0] snoop_address_A,
  output logic [AW-1:0] snoop_address_B
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          owner;   // 0 = core A, 1 = core B
  logic          op_wr;
  logic          prio_b;

  logic          req_a_c;
  logic          req_b_c;
  logic          grant_b_c;
  logic          grant_wr_c;
  logic [AW-1:0] grant_addr_c;
  logic [n-1:0]  grant_data_c;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0]    starve_a;
  logic [3:0]    starve_b;

  // Count the other core's completions while this core waits; own completion clears.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      starve_a <= 4'd0;
      starve_b <= 4'd0;
    end else if (state == DONE) begin
      if (owner) begin
        starve_b <= 4'd0;
        if (req_a_c && starve_a != 4'd15) starve_a <= starve_a + 4'd1;
      end else begin
        starve_a <= 4'd0;
        if (req_b_c && starve_b != 4'd15) starve_b <= starve_b + 4'd1;
      end
    end
  end
`endif

  assign req_a_c = L1A_READ_REQUEST | L1A_WRITE_REQUEST;
  assign req_b_c = L1B_READ_REQUEST | L1B_WRITE_REQUEST;

  // Arbitration: a lone requester wins, otherwise the priority pointer decides.
  always_comb begin
    grant_b_c = req_b_c;
    if (req_a_c && req_b_c) begin
      grant_b_c = prio_b;
`ifdef ARB_STARVE_GUARD_EN
      if (starve_a == 4'd15)      grant_b_c = 1'b0;
      else if (starve_b == 4'd15) grant_b_c = 1'b1;
`endif
    end
    grant_wr_c   = grant_b_c ? L1B_WRITE_REQUEST : L1A_WRITE_REQUEST;
    grant_addr_c = grant_b_c ? L1B_word_address  : L1A_word_address;
    grant_data_c = grant_b_c ? L1B_write_word    : L1A_write_word;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state                   <= IDLE;
      owner                   <= 1'b0;
      op_wr                   <= 1'b0;
      prio_b                  <= 1'b0;
      L2_read_request         <= 1'b0;
      L2_write_request        <= 1'b0;
      L2_word_address         <= '0;
      L2_rdata                <= '0;
      L1A_read_word           <= '0;
      L1B_read_word           <= '0;
      done_A                  <= 1'b0;
      done_B                  <= 1'b0;
      L2_busy_out_A           <= 1'b0;
      L2_busy_out_B           <= 1'b0;
      others_read_requests_A  <= 1'b0;
      others_read_requests_B  <= 1'b0;
      others_write_requests_A <= 1'b0;
      others_write_requests_B <= 1'b0;
      snoop_address_A         <= '0;
      snoop_address_B         <= '0;
    end else begin
      done_A <= 1'b0;
      done_B <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a_c || req_b_c) begin
            state                   <= ISSUE;
            owner                   <= grant_b_c;
            op_wr                   <= grant_wr_c;
            L2_word_address         <= grant_addr_c;
            L2_rdata                <= grant_data_c;
            L2_read_request         <= ~grant_wr_c;
            L2_write_request        <= grant_wr_c;
            L2_busy_out_A           <= 1'b1;
            L2_busy_out_B           <= 1'b1;
            others_read_requests_A  <= grant_b_c & ~grant_wr_c;
            others_write_requests_A <= grant_b_c & grant_wr_c;
            others_read_requests_B  <= ~grant_b_c & ~grant_wr_c;
            others_write_requests_B <= ~grant_b_c & grant_wr_c;
            snoop_address_A         <= grant_b_c ? grant_addr_c : '0;
            snoop_address_B         <= grant_b_c ? '0 : grant_addr_c;
          end
        end
        ISSUE: begin
          if (L2_busy_in) begin
            state            <= WAIT;
            L2_read_request  <= 1'b0;
            L2_write_request <= 1'b0;
          end
        end
        WAIT: begin
          if (!L2_busy_in) begin
            state <= DONE;
            if (!op_wr) begin
              if (owner) L1B_read_word <= L2_wdata;
              else       L1A_read_word <= L2_wdata;
            end
            done_A                  <= ~owner;
            done_B                  <= owner;
            // Owner sees the port free during its done cycle; the other core does not.
            if (owner) L2_busy_out_B <= 1'b0;
            else       L2_busy_out_A <= 1'b0;
            others_read_requests_A  <= 1'b0;
            others_read_requests_B  <= 1'b0;
            others_write_requests_A <= 1'b0;
            others_write_requests_B <= 1'b0;
            snoop_address_A         <= '0;
            snoop_address_B         <= '0;
          end
        end
        DONE: begin
          state         <= IDLE;
          prio_b        <= ~owner;
          L2_busy_out_A <= 1'b0;
          L2_busy_out_B <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
